// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
// -----------------
// Round-robin N:1 arbiter that shares one downstream stream channel among
// NUM_PORTS first-word fall-through FIFO read sides. Each grant is a burst of
// up to MAX_BURST words. Output write/data/id are registered.
//
// Handshake semantics (one place for all of them):
//   upstream   : a word moves out of port k in a cycle where
//                in_empty_n[k] & in_read[k] is high at the rising clk edge;
//                in_dout[k] is the head word and is valid whenever
//                in_empty_n[k] is high (FWFT).
//   downstream : out_full_n is sampled in the pop cycle; a word is accepted
//                on every cycle out_write is high (the downstream guarantees
//                room for at least one write after dropping out_full_n).
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   in_empty_n  per-port "data valid"
//   in_read     per-port pop strobe, one-hot or zero
//   in_dout     per-port head words, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_full_n  downstream space available
//   out_write   registered write strobe
//   out_din     registered write data
//   out_id      registered source port of out_din
//   busy        high while a port holds the grant
//   dbg_state   current FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr     current highest-priority port
module stream_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int ID_WIDTH  = $clog2(NUM_PORTS),
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            in_empty_n,
  output logic [NUM_PORTS-1:0]            in_read,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
  input  logic                            out_full_n,
  output logic                            out_write,
  output logic [DATA_WIDTH-1:0]           out_din,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic                            busy,
  output logic                            dbg_state,
  output logic [ID_WIDTH-1:0]             dbg_ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state, state_d;
  logic [ID_WIDTH-1:0]  ptr, ptr_d;
  logic [ID_WIDTH-1:0]  gnt, gnt_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;

  logic [ID_WIDTH-1:0]  sel;
  logic                 sel_valid;
  logic [ID_WIDTH-1:0]  gnt_inc;
  logic                 pop;
  logic                 cnt_last;

  // Scan ptr, ptr+1, ... modulo NUM_PORTS. Walking the offsets from highest
  // to lowest lets the closest requester overwrite any farther one.
  always_comb begin : pick
    int                  idx;
    logic [ID_WIDTH-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_w = ID_WIDTH'(idx);
      if (in_empty_n[idx_w]) begin
        sel       = idx_w;
        sel_valid = 1'b1;
      end
    end
  end

  // Explicit wrap so non-power-of-two port counts return to 0.
  assign gnt_inc  = (gnt == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : gnt + ID_WIDTH'(1);
  assign pop      = (state == GRANT) & in_empty_n[gnt] & out_full_n;
  assign cnt_last = (cnt == CNT_WIDTH'(MAX_BURST - 1));

  // Pop strobe is decoded from state and the granted port's valid/full only,
  // so there is no combinational path from in_dout.
  always_comb begin
    in_read = '0;
    if (state == GRANT) in_read[gnt] = in_empty_n[gnt] & out_full_n;
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gnt_d   = gnt;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_d = GRANT;
          gnt_d   = sel;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (pop) begin
          cnt_d = cnt + CNT_WIDTH'(1);
          if (cnt_last) begin
            state_d = IDLE;
            ptr_d   = gnt_inc;
          end
        end else if (!in_empty_n[gnt]) begin
          // Port drained: release early. Backpressure alone never releases.
          state_d = IDLE;
          ptr_d   = gnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_write <= 1'b0;
      out_din   <= '0;
      out_id    <= '0;
    end else begin
      out_write <= pop;
      if (pop) begin
        out_din <= in_dout[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        out_id  <= gnt;
      end
    end
  end

  assign busy      = (state == GRANT);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;
  localparam int DW = 32;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b1;

  int checks = 0;
  int failures = 0;

  // ---------------- 4-port instance (MAX_BURST 8) ----------------
  logic [3:0]      in_empty_n4, in_read4;
  logic [3:0]      en4 = '0;
  logic [4*DW-1:0] in_dout4;
  logic            out_full_n = 1'b1;
  logic            out_write4;
  logic [DW-1:0]   out_din4;
  logic [1:0]      out_id4;
  logic            busy4, dbg_state4;
  logic [1:0]      dbg_ptr4;
  int              pops4[4];
  int              limit4[4];

  // ---------------- 3-port instance (MAX_BURST 8) ----------------
  logic [2:0]      in_empty_n3, in_read3;
  logic [2:0]      en3 = '0;
  logic [3*DW-1:0] in_dout3;
  logic            out_full_n3 = 1'b1;
  logic            out_write3;
  logic [DW-1:0]   out_din3;
  logic [1:0]      out_id3;
  logic            busy3, dbg_state3;
  logic [1:0]      dbg_ptr3;
  int              pops3[3];
  int              limit3[3];

  stream_rr_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(DW), .MAX_BURST(8)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_empty_n(in_empty_n4), .in_read(in_read4),
    .in_dout(in_dout4), .out_full_n(out_full_n), .out_write(out_write4),
    .out_din(out_din4), .out_id(out_id4), .busy(busy4),
    .dbg_state(dbg_state4), .dbg_ptr(dbg_ptr4)
  );

  stream_rr_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(DW), .MAX_BURST(8)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_empty_n(in_empty_n3), .in_read(in_read3),
    .in_dout(in_dout3), .out_full_n(out_full_n3), .out_write(out_write3),
    .out_din(out_din3), .out_id(out_id3), .busy(busy3),
    .dbg_state(dbg_state3), .dbg_ptr(dbg_ptr3)
  );

  // FWFT source models: port k presents words k*256 + n, n = words popped.
  for (genvar k = 0; k < 4; k++) begin : g_src4
    assign in_empty_n4[k] = en4[k] && (pops4[k] < limit4[k]);
    assign in_dout4[k*DW +: DW] = DW'(k*256 + pops4[k]);
  end
  for (genvar k = 0; k < 3; k++) begin : g_src3
    assign in_empty_n3[k] = en3[k] && (pops3[k] < limit3[k]);
    assign in_dout3[k*DW +: DW] = DW'(k*256 + pops3[k]);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) pops4[k] <= 0;
      for (int k = 0; k < 3; k++) pops3[k] <= 0;
    end else begin
      for (int k = 0; k < 4; k++) if (in_read4[k] === 1'b1) pops4[k] <= pops4[k] + 1;
      for (int k = 0; k < 3; k++) if (in_read3[k] === 1'b1) pops3[k] <= pops3[k] + 1;
    end
  end

  // ---------------- logs / scoreboard ----------------
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];
  logic [33:0] obs3_q[$];
  logic        trace_q[$];

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
    obs3_q.delete();
    trace_q.delete();
  endtask

  // Advance to the next falling edge and log what the outputs show there.
  task automatic tick();
    @(negedge clk);
    trace_q.push_back(out_write4);
    if (out_write4) obs_q.push_back({out_id4, out_din4});
    if (out_write3) obs3_q.push_back({out_id3, out_din3});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    if (out_write4 !== 1'b0) begin failures++; $display("FAIL rst_out_write: got %b expected 0", out_write4); end
    checks++;
    if (out_din4 !== '0) begin failures++; $display("FAIL rst_out_din: got %0h expected 0", out_din4); end
    checks++;
    if (out_id4 !== 2'd0) begin failures++; $display("FAIL rst_out_id: got %0d expected 0", out_id4); end
    checks++;
    if (in_read4 !== 4'b0) begin failures++; $display("FAIL rst_in_read: got %b expected 0000", in_read4); end
    checks++;
    if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy4); end
    checks++;
    if (dbg_ptr4 !== 2'd0 || dbg_ptr3 !== 2'd0) begin
      failures++; $display("FAIL rst_ptr: got %0d/%0d expected 0/0", dbg_ptr4, dbg_ptr3);
    end
    checks++;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (dbg_state4 !== ST_IDLE || busy4 !== 1'b0 || out_write4 !== 1'b0 || in_read4 !== 4'b0) begin
        failures++;
        $display("FAIL idle_hold: got state=%b busy=%b write=%b read=%b expected 0 0 0 0000",
                 dbg_state4, busy4, out_write4, in_read4);
      end
      checks++;
    end
  endtask

  task automatic test_round_robin();
    int onehot_err;
    onehot_err = 0;
    clear_logs();
    en4 = 4'hF;
    for (int k = 0; k < 4; k++) limit4[k] = 1000;
    for (int c = 0; c < 45; c++) begin
      tick();
      if ($countones(in_read4) > 1) onehot_err++;
    end
    en4 = '0;
    for (int b = 0; b < 5; b++)
      for (int n = 0; n < 8; n++)
        exp_q.push_back({2'(b % 4), DW'((b % 4) * 256 + (b / 4) * 8 + n)});
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    checks++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rr_word[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
      end
      checks++;
    end
    for (int i = 0; i < 45; i++) begin
      if (trace_q[i] !== ((i % 9) != 0)) begin
        failures++; $display("FAIL rr_bubble[%0d]: got %b expected %b", i, trace_q[i], (i % 9) != 0);
      end
      checks++;
    end
    if (onehot_err != 0) begin failures++; $display("FAIL rr_onehot: got %0d errors expected 0", onehot_err); end
    checks++;
    if (dbg_state4 !== ST_IDLE || dbg_ptr4 !== 2'd1) begin
      failures++; $display("FAIL rr_end: got state=%b ptr=%0d expected 0 1", dbg_state4, dbg_ptr4);
    end
    checks++;
  endtask

  task automatic test_early_release();
    int base;
    // One word from port 1 moves the pointer to 2.
    en4 = 4'b0010;
    limit4[1] = pops4[1] + 1;
    for (int c = 0; c < 4; c++) tick();
    en4 = '0;
    if (dbg_ptr4 !== 2'd2) begin failures++; $display("FAIL er_setup_ptr: got %0d expected 2", dbg_ptr4); end
    checks++;
    clear_logs();
    base = pops4[2];
    en4 = 4'b0100;
    limit4[2] = pops4[2] + 3;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 3) begin
        if (in_empty_n4[2] !== 1'b0 || dbg_state4 !== ST_GRANT || busy4 !== 1'b1) begin
          failures++;
          $display("FAIL er_drain_cycle: got valid=%b state=%b busy=%b expected 0 1 1",
                   in_empty_n4[2], dbg_state4, busy4);
        end
        checks++;
      end
    end
    en4 = '0;
    if (dbg_state4 !== ST_IDLE || busy4 !== 1'b0) begin
      failures++; $display("FAIL er_idle: got state=%b busy=%b expected 0 0", dbg_state4, busy4);
    end
    checks++;
    if (dbg_ptr4 !== 2'd3) begin failures++; $display("FAIL er_ptr: got %0d expected 3", dbg_ptr4); end
    checks++;
    for (int n = 0; n < 3; n++) exp_q.push_back({2'd2, DW'(2 * 256 + base + n)});
    if (obs_q.size() != 3) begin failures++; $display("FAIL er_count: got %0d expected 3", obs_q.size()); end
    checks++;
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL er_word[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic exp_w;
    clear_logs();
    base = pops4[3];
    en4 = 4'b1000;
    limit4[3] = pops4[3] + 1000;
    out_full_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c >= 5 && c <= 9) begin
        if (in_read4 !== 4'b0 || busy4 !== 1'b1 || dbg_state4 !== ST_GRANT) begin
          failures++;
          $display("FAIL bp_hold[%0d]: got read=%b busy=%b state=%b expected 0000 1 1",
                   c, in_read4, busy4, dbg_state4);
        end
        checks++;
      end
      if (c == 4) begin
        out_full_n = 1'b0;
        #1;
        if (in_read4 !== 4'b0) begin failures++; $display("FAIL bp_read_drop: got %b expected 0000", in_read4); end
        checks++;
      end
      if (c == 9) out_full_n = 1'b1;
      if (c == 13) en4 = '0;
    end
    for (int i = 0; i < 15; i++) begin
      exp_w = (i >= 1 && i <= 4) || (i >= 10 && i <= 13);
      if (trace_q[i] !== exp_w) begin
        failures++; $display("FAIL bp_trace[%0d]: got %b expected %b", i, trace_q[i], exp_w);
      end
      checks++;
    end
    for (int n = 0; n < 8; n++) exp_q.push_back({2'd3, DW'(3 * 256 + base + n)});
    if (obs_q.size() != 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", obs_q.size()); end
    checks++;
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL bp_word[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]);
      end
      checks++;
    end
    if (dbg_state4 !== ST_IDLE || dbg_ptr4 !== 2'd0) begin
      failures++; $display("FAIL bp_end: got state=%b ptr=%0d expected 0 0", dbg_state4, dbg_ptr4);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    en4 = 4'b0010;
    limit4[1] = pops4[1] + 1;
    for (int c = 0; c < 4; c++) tick();
    if (dbg_ptr4 !== 2'd2) begin failures++; $display("FAIL ar_setup_ptr: got %0d expected 2", dbg_ptr4); end
    checks++;
    clear_logs();
    en4 = 4'b0100;
    limit4[2] = pops4[2] + 100;
    for (int c = 0; c < 4; c++) tick();
    if (obs_q.size() != 3 || busy4 !== 1'b1) begin
      failures++; $display("FAIL ar_pre: got words=%0d busy=%b expected 3 1", obs_q.size(), busy4);
    end
    checks++;
    #2 reset_n = 1'b0;
    #1;
    if (dbg_state4 !== ST_IDLE || busy4 !== 1'b0 || out_write4 !== 1'b0 || in_read4 !== 4'b0 || out_din4 !== '0) begin
      failures++;
      $display("FAIL ar_immediate: got state=%b busy=%b write=%b read=%b din=%0h expected 0 0 0 0000 0",
               dbg_state4, busy4, out_write4, in_read4, out_din4);
    end
    checks++;
    if (dbg_ptr4 !== 2'd0) begin failures++; $display("FAIL ar_ptr: got %0d expected 0", dbg_ptr4); end
    checks++;
    tick();
    reset_n = 1'b1;
    clear_logs();
    en4 = 4'hF;
    for (int k = 0; k < 4; k++) limit4[k] = 1000;
    tick();
    tick();
    if (out_write4 !== 1'b1 || out_id4 !== 2'd0 || out_din4 !== 32'd0) begin
      failures++;
      $display("FAIL ar_restart: got write=%b id=%0d din=%0h expected 1 0 0", out_write4, out_id4, out_din4);
    end
    checks++;
    en4 = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap_sparse();
    int seen1;
    int nxt[3];
    int id;
    seen1 = 0;
    en3 = 3'b010;
    limit3[1] = pops3[1] + 1;
    for (int c = 0; c < 4; c++) tick();
    en3 = '0;
    if (dbg_ptr3 !== 2'd2) begin failures++; $display("FAIL wr_setup_ptr: got %0d expected 2", dbg_ptr3); end
    checks++;
    clear_logs();
    for (int k = 0; k < 3; k++) nxt[k] = pops3[k];
    en3 = 3'b101;
    limit3[0] = pops3[0] + 1000;
    limit3[2] = pops3[2] + 1000;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (in_read3[1] === 1'b1) seen1++;
      if (c == 8) begin
        if (dbg_ptr3 !== 2'd0 || dbg_state3 !== ST_IDLE) begin
          failures++; $display("FAIL wr_ptr_wrap: got ptr=%0d state=%b expected 0 0", dbg_ptr3, dbg_state3);
        end
        checks++;
      end
    end
    en3 = '0;
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < 8; n++) begin
        id = (b % 2 == 0) ? 2 : 0;
        exp_q.push_back({2'(id), DW'(id * 256 + nxt[id])});
        nxt[id]++;
      end
    if (obs3_q.size() != 32) begin failures++; $display("FAIL wr_count: got %0d expected 32", obs3_q.size()); end
    checks++;
    for (int i = 0; i < 32 && i < obs3_q.size(); i++) begin
      if (obs3_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL wr_word[%0d]: got %0h expected %0h", i, obs3_q[i], exp_q[i]);
      end
      checks++;
    end
    if (seen1 != 0) begin failures++; $display("FAIL wr_port1: got %0d grants expected 0", seen1); end
    checks++;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) limit4[k] = 0;
    for (int k = 0; k < 3; k++) limit3[k] = 0;
    test_reset();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_async_reset();
    test_wrap_sparse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
